seq_pattern_tx: RTL and testbench

- Moore-style serial pattern generator. It is the transmit-side counterpart to the team's serial sequence detectors.
- Shifts a programmable WIDTH-bit pattern out MSB-first on a 1-bit line, repeated a requested number of times, with optional idle gap cycles between repetitions.
- Used to drive detector inputs in system tests and as a framing-pattern source for serial links.

---
 rtl/seq_pkg.sv | 6 +
 rtl/seq_shift_reg.sv | 18 +
 rtl/seq_pattern_tx.sv | 73 +++++++
 tb/tb_seq_pattern_tx.sv | 108 ++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: state encodings and default pattern shared by pattern generators and detector benches
package seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;
  localparam int DEF_WIDTH = 4;
  localparam logic [DEF_WIDTH-1:0] DEF_PAT = 4'b1001;
endpackage

// File: rtl/seq_shift_reg.sv
// seq_shift_reg: parallel-load left-shift register with serial MSB output
module seq_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             msb
);
  logic [WIDTH-1:0] q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= '0;
    else if (load) q <= d;
    else if (shift) q <= {q[WIDTH-2:0], 1'b0};
  assign msb = q[WIDTH-1];
endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: Moore serial pattern generator, MSB-first, repeated with optional idle gaps
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] DEF_PATTERN = DEF_PAT,
  parameter int               GAP_CYCLES  = 0,
  parameter int               CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             pat_load,
  input  logic [WIDTH-1:0] pat_in,
  input  logic [CNT_W-1:0] reps,
  output logic             op,
  output logic             op_valid,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  state_t state, next;
  logic [BW-1:0] bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic [WIDTH-1:0] pat_reg;
  logic msb;
  logic idle_start, last_bit, rep_end, gap_end, to_gap, load, shift;
  logic [WIDTH-1:0] load_val;
  assign idle_start = state == IDLE && start;
  assign last_bit   = state == SEND && bit_cnt == BW'(1);
  assign rep_end    = last_bit && rep_cnt <= CNT_W'(1);
  assign gap_end    = state == GAP && gap_cnt <= GW'(1);
  assign to_gap     = last_bit && !rep_end && GAP_CYCLES > 0;
  assign load       = (idle_start && reps != '0) || (last_bit && !rep_end && GAP_CYCLES == 0) || gap_end;
  assign shift      = state == SEND;
  // A same-cycle pat_load feeds the new pattern straight into this transmission
  assign load_val   = (state == IDLE && pat_load) ? pat_in : pat_reg;
  seq_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk(clk), .reset_n(reset_n), .load(load), .shift(shift), .d(load_val), .msb(msb)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    unique case (state)
      IDLE: next = start ? (reps == '0 ? DONE : SEND) : IDLE;
      SEND: next = !last_bit ? SEND : rep_end ? DONE : (GAP_CYCLES > 0 ? GAP : SEND);
      GAP:  next = gap_end ? SEND : GAP;
      DONE: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pat_reg <= DEF_PATTERN;
      bit_cnt <= '0;
      gap_cnt <= '0;
      rep_cnt <= '0;
    end else begin
      if (state == IDLE && pat_load) pat_reg <= pat_in;
      bit_cnt <= load ? BW'(WIDTH) : (shift && bit_cnt != '0) ? bit_cnt - 1'b1 : bit_cnt;
      rep_cnt <= idle_start ? reps : (last_bit && rep_cnt != '0) ? rep_cnt - 1'b1 : rep_cnt;
      gap_cnt <= to_gap ? GW'(GAP_CYCLES) : (state == GAP && gap_cnt != '0) ? gap_cnt - 1'b1 : gap_cnt;
    end
  always_comb begin
    op_valid = state == SEND;
    op       = op_valid ? msb : 1'b0;
    busy     = state == SEND || state == GAP;
    done     = state == DONE;
  end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: gap-free and two-gap generators driven in parallel, checked against a frame-list model
module tb_seq_pattern_tx;
  import seq_pkg::*;
  typedef logic [3:0] obs_t;
  logic clk = 0, reset_n = 0, start = 0, pat_load = 0;
  logic [3:0] pat_in = '0, reps = '0;
  logic op0, v0, b0, d0, op2, v2, b2, d2;
  int checks = 0, passed = 0;
  logic [3:0] pat_m;
  obs_t q0[$], q2[$];
  always #5 clk = ~clk;
  seq_pattern_tx #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .pat_load(pat_load), .pat_in(pat_in), .reps(reps),
    .op(op0), .op_valid(v0), .busy(b0), .done(d0)
  );
  seq_pattern_tx #(.GAP_CYCLES(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .pat_load(pat_load), .pat_in(pat_in), .reps(reps),
    .op(op2), .op_valid(v2), .busy(b2), .done(d2)
  );
  // Expected per-cycle {op, op_valid, busy, done} stream after the accepting edge
  function automatic void model(input int r);
    q0 = {};
    q2 = {};
    for (int k = 0; k < r; k++) begin
      for (int b = 3; b >= 0; b--) begin
        q0.push_back({pat_m[b], 3'b110});
        q2.push_back({pat_m[b], 3'b110});
      end
      if (k < r - 1) for (int g = 0; g < 2; g++) q2.push_back(4'b0010);
    end
    q0.push_back(4'b0001);
    q2.push_back(4'b0001);
  endfunction
  task automatic check(input string tag, input obs_t got, input obs_t exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%b exp=%b", tag, got, exp);
  endtask
  task automatic check_both(input string tag);
    obs_t e0, e2;
    e0 = q0.size() != 0 ? q0.pop_front() : 4'b0000;
    e2 = q2.size() != 0 ? q2.pop_front() : 4'b0000;
    check({tag, " gap0"}, {op0, v0, b0, d0}, e0);
    check({tag, " gap2"}, {op2, v2, b2, d2}, e2);
  endtask
  // Called #1 after a rising edge with both instances idle
  task automatic send(input string tag, input logic ld, input logic [3:0] pin, input logic [3:0] r,
                      input bit noise, input logic [3:0] npat);
    int n, minl;
    start = 1; pat_load = ld; pat_in = pin; reps = r;
    if (ld) pat_m = pin;
    model(int'(r));
    minl = q0.size() < q2.size() ? q0.size() : q2.size();
    n = (q0.size() > q2.size() ? q0.size() : q2.size()) + 1;
    for (int j = 1; j <= n; j++) begin
      @(posedge clk); #1;
      check_both($sformatf("%s c%0d", tag, j));
      start    = noise && j < minl;
      pat_load = noise && j < minl;
      pat_in   = (noise && j < minl) ? npat : 4'b0000;
      reps     = (noise && j < minl) ? 4'($urandom) : 4'b0000;
    end
  endtask
  initial begin
    pat_m = DEF_PAT;
    repeat (2) @(posedge clk);
    #1;
    q0 = {}; q2 = {};
    check_both("reset");
    reset_n = 1;
    @(posedge clk); #1;
    send("def_r1", 0, 4'b0000, 4'd1, 0, 4'b0000);
    send("gap_r3", 0, 4'b0000, 4'd3, 0, 4'b0000);
    send("load_r2", 1, 4'b1011, 4'd2, 0, 4'b0000);
    send("kept1011", 0, 4'b0000, 4'd1, 0, 4'b0000);
    send("reps0", 0, 4'b0000, 4'd0, 0, 4'b0000);
    send("load1001", 1, 4'b1001, 4'd2, 0, 4'b0000);
    send("ignore", 0, 4'b0000, 4'd2, 1, 4'b0110);
    send("still1001", 0, 4'b0000, 4'd1, 0, 4'b0000);
    send("max_reps", 0, 4'b0000, 4'd15, 0, 4'b0000);
    for (int i = 0; i < 8; i++)
      send($sformatf("rnd%0d", i), 1'($urandom), 4'($urandom), 4'($urandom_range(0, 5)),
           1'($urandom), 4'($urandom));
    start = 1; pat_load = 1; pat_in = 4'b0110; reps = 4'd3;
    pat_m = 4'b0110;
    model(3);
    for (int j = 1; j <= 7; j++) begin
      @(posedge clk); #1;
      check_both($sformatf("pre_rst c%0d", j));
      start = 0; pat_load = 0; pat_in = 4'b0000; reps = 4'd0;
    end
    #2 reset_n = 0;
    #1;
    q0 = {}; q2 = {};
    check_both("async_rst");
    for (int j = 1; j <= 2; j++) begin
      @(posedge clk); #1;
      check_both($sformatf("in_rst c%0d", j));
    end
    reset_n = 1;
    pat_m = DEF_PAT;
    @(posedge clk); #1;
    check_both("post_rst");
    send("restored", 0, 4'b0000, 4'd1, 0, 4'b0000);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
